// File: rtl/stream_unzigzag.sv
// stream_unzigzag: ping-pong buffer that reorders zigzag-scanned 8x8 coefficient beats into a natural block.
// Define UNZIGZAG_EOB_EN to compile in early end-of-block (in_eob) support with per-bank written masks.
module stream_unzigzag #(
    parameter int Q         = 12,
    parameter int LANES     = 1,
    parameter int COL_MAJOR = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0][Q-1:0] in_coef,
`ifdef UNZIGZAG_EOB_EN
    input  logic                    in_eob,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [Q-1:0]     out_block [8][8],
    output logic                    proto_err
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [5:0] STEP      = 6'(LANES);
    localparam logic [5:0] LAST_BASE = 6'(64 - LANES);

    // Natural position (row*8 + col) of each zigzag scan index.
    localparam logic [5:0] ZZ_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [1:0]   bank_st_q [2];
    logic [1:0]   bank_st_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [5:0]   wr_idx_q, wr_idx_d;
    logic         in_ready_q, in_ready_d;
    logic         proto_err_q, proto_err_d;
    logic [Q-1:0] mem_q [2][64];
    logic [Q-1:0] mem_d [2][64];
`ifdef UNZIGZAG_EOB_EN
    logic [63:0]  mask_q [2];
    logic [63:0]  mask_d [2];
`endif

    logic accept;
    logic consume;
    logic last_beat;

    assign in_ready  = in_ready_q;
    assign proto_err = proto_err_q;
    assign out_valid = (bank_st_q[rd_ptr_q] == ST_FULL);
    assign accept    = in_valid && in_ready_q;
    assign consume   = out_valid && out_ready;

`ifdef UNZIGZAG_EOB_EN
    assign last_beat = (wr_idx_q == LAST_BASE) || in_eob;
`else
    assign last_beat = (wr_idx_q == LAST_BASE);
`endif

    // Bank bookkeeping. The write bank is never FULL and the read bank is only consumed when FULL,
    // so a same-cycle fill completion and drain always touch different banks.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bank_st_d   = bank_st_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_idx_d    = wr_idx_q;
        proto_err_d = proto_err_q || (in_valid && !in_ready_q);

        if (consume) begin
            bank_st_d[rd_ptr_q] = ST_EMPTY;
            rd_ptr_d            = !rd_ptr_q;
        end

        if (accept) begin
            if (last_beat) begin
                bank_st_d[wr_ptr_q] = ST_FULL;
                wr_idx_d            = '0;
                wr_ptr_d            = !wr_ptr_q;
            end else begin
                bank_st_d[wr_ptr_q] = ST_FILLING;
                wr_idx_d            = wr_idx_q + STEP;
            end
        end

        in_ready_d = (bank_st_d[wr_ptr_d] != ST_FULL);
    end

    // Coefficient storage is written in natural order so the output is a plain bank read.
    always_comb begin
        mem_d = mem_q;
`ifdef UNZIGZAG_EOB_EN
        mask_d = mask_q;
        if (consume) begin
            mask_d[rd_ptr_q] = '0;
        end
`endif
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                mem_d[wr_ptr_q][ZZ_NAT[wr_idx_q + 6'(k)]] = in_coef[k];
`ifdef UNZIGZAG_EOB_EN
                mask_d[wr_ptr_q][ZZ_NAT[wr_idx_q + 6'(k)]] = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        logic [5:0] nat;
        nat = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                nat = (COL_MAJOR != 0) ? {c[2:0], r[2:0]} : {r[2:0], c[2:0]};
                out_block[r][c] = '0;
`ifdef UNZIGZAG_EOB_EN
                if (out_valid && mask_q[rd_ptr_q][nat]) begin
                    out_block[r][c] = mem_q[rd_ptr_q][nat];
                end
`else
                if (out_valid) begin
                    out_block[r][c] = mem_q[rd_ptr_q][nat];
                end
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            bank_st_q[0] <= ST_EMPTY;
            bank_st_q[1] <= ST_EMPTY;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            wr_idx_q     <= '0;
            in_ready_q   <= 1'b0;
            proto_err_q  <= 1'b0;
`ifdef UNZIGZAG_EOB_EN
            mask_q[0]    <= '0;
            mask_q[1]    <= '0;
`endif
        end else begin
            bank_st_q   <= bank_st_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_idx_q    <= wr_idx_d;
            in_ready_q  <= in_ready_d;
            proto_err_q <= proto_err_d;
`ifdef UNZIGZAG_EOB_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // NOTE: the data array has no reset; it is only visible through a FULL bank, whose positions are
    // all rewritten (or masked) before it can become FULL.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/stream_unzigzag.md
STREAM_UNZIGZAG -- requirements
Module: stream_unzigzag

Interface
REQ-001 SHALL have parameter Q, default 12: coefficient width in bits, signed two's complement.
REQ-002 SHALL have parameter LANES, default 1: coefficients per input beat; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter COL_MAJOR, default 0: 0 = out_block[r][c] natural; 1 = out_block[c][r] transposed for the column IDCT pass.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_coef  input  LANES x Q  coefficients; lane k holds zigzag index base+k.
REQ-009 SHALL have port in_eob  input  1  end-of-block on this beat; present only with UNZIGZAG_EOB_EN.
REQ-010 SHALL have port out_valid  output  1  out_block holds a complete block.
REQ-011 SHALL have port out_ready  input  1  consumer accepts block when out_valid && out_ready.
REQ-012 SHALL have port out_block  output  8 x 8 x Q signed  de-zigzagged block.
REQ-013 SHALL have port proto_err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL hold two 64-entry banks (ping-pong), each with state EMPTY, FILLING or FULL.
REQ-015 Write index SHALL start at 0 and advance by LANES per accepted beat; lane k writes zigzag index idx+k to natural position (row, col) of the standard JPEG zigzag scan.
REQ-016 A bank SHALL go FULL on the beat writing index 63 (or on in_eob); write index SHALL wrap to 0, and the write pointer SHALL toggle to the other bank.
REQ-017 in_ready SHALL be registered: high iff the write-pointer bank is EMPTY or FILLING.
REQ-018 out_valid SHALL be high iff the read-pointer bank is FULL; out_block SHALL be driven from that bank and held stable while out_valid && !out_ready.
REQ-019 On out_valid && out_ready the read bank SHALL become EMPTY next cycle and the read pointer SHALL toggle.
REQ-020 Latency: out_valid SHALL rise exactly one cycle after the completing beat is accepted, when that bank is the read bank.
REQ-021 Accepting the completing beat into one bank and consuming the other bank in the same cycle SHALL both take effect; no beat or block lost.
REQ-022 With both banks FULL, in_ready SHALL be 0; a bank freed in cycle t SHALL raise in_ready in cycle t+1.
REQ-023 Sustained throughput SHALL be one block per 64/LANES cycles with out_ready held high.
REQ-024 in_valid && !in_ready SHALL set proto_err; input SHALL be ignored.
REQ-025 COL_MAJOR SHALL affect only out_block mapping, not timing.

Reset
REQ-026 reset_n low SHALL asynchronously force both banks EMPTY, pointers and write index 0, in_ready 0, out_valid 0, proto_err 0, out_block all zero.
REQ-027 in_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-028 Reset mid-block SHALL discard partial and full banks; no stale block appears afterwards.

Configuration
REQ-029 Macro UNZIGZAG_EOB_EN SHALL compile in early end-of-block support.
REQ-030 With UNZIGZAG_EOB_EN: in_eob on an accepted beat SHALL complete the bank after writing that beat's lanes; all unwritten positions SHALL read as 0 (per-bank 64-bit written mask, cleared on EMPTY).
REQ-031 With UNZIGZAG_EOB_EN: in_eob on the beat writing index 63 SHALL behave as a normal completion.
REQ-032 Without UNZIGZAG_EOB_EN: port in_eob and mask logic SHALL be absent; a block SHALL be exactly 64/LANES beats.

Verification
REQ-033 LANES=1: feed zigzag indices 0..63 with value = index, out_ready=1 -> out_block[r][c] = zigzag index of (r,c), e.g. [0][1]=1, [1][0]=2, [7][7]=63; out_valid one cycle after beat 64.
REQ-034 LANES=4, COL_MAJOR=1: same data in 16 beats -> out_block[1][0]=1, [0][1]=2; out_valid on cycle 17.
REQ-035 out_ready=0, three back-to-back blocks -> in_ready drops after 128 accepted beats, block 1 held stable; raise out_ready -> blocks 1,2 delivered in order, in_ready returns next cycle.
REQ-036 EOB_EN, LANES=1: indices 0..5 with in_eob on beat 6 (value 7) -> positions of zigzag 0..5 hold data, all 58 others read 0; next block fully written is unaffected by mask.
REQ-037 Assert reset_n low after 30 beats of block 2 with block 1 pending -> out_valid 0 immediately; fresh block after reset delivered intact.
REQ-038 Drive in_valid while both banks FULL -> proto_err 1 and stays 1 until reset; no data corruption.
